// File: rtl/fa2_serial_pkg.sv
// Shared types and helpers for the serial 2-bit-slice adder controller.
// Optional feature macro used by the controller: FA2_SERIAL_OVF_EN.
package fa2_serial_pkg;

   // Encodings are pinned so the debug state output is stable across builds.
   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_RUN  = 2'd1;
   localparam logic [1:0] ENC_FIN  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ENC_IDLE,
      ST_RUN  = ENC_RUN,
      ST_FIN  = ENC_FIN
   } state_t;

   // Digit counter width: clog2(width/2), but never below one bit so that a
   // single-digit adder (width 2) still has a legal counter register.
   function automatic int cnt_bits(input int width);
      int n;
      int b;
      n = width / 2;
      b = 0;
      while ((1 << b) < n) b++;
      return (b < 1) ? 1 : b;
   endfunction

endpackage

// File: rtl/fa2_serial_ctrl_add2_slice.sv
// Combinational 2-bit ripple-carry adder slice. c0 is the carry out of bit 0,
// i.e. the carry into bit 1, which the controller uses for signed overflow.
module add2_slice (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       ci,
   output logic [1:0] sum,
   output logic       c0,
   output logic       co
);

   // Two chained full adders.
   always_comb begin
      sum[0] = a[0] ^ b[0] ^ ci;
      c0     = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
      sum[1] = a[1] ^ b[1] ^ c0;
      co     = (a[1] & b[1]) | (c0 & (a[1] ^ b[1]));
   end

endmodule

// File: rtl/fa2_serial_ctrl.sv
// Serial WIDTH-bit adder controller: one shared 2-bit slice, two bits per
// cycle, LSB pair first, carry held in a register between digits.
// Optional signed-overflow output is enabled by defining FA2_SERIAL_OVF_EN.
//
// Handshake: start is sampled on every rising edge; it is accepted only in
// IDLE or FIN (busy low), where a, b and ci are captured. While busy is high
// start is ignored and not queued. done is a one-cycle pulse during which
// sum/co (and ovf) hold the new result; they keep that value until the next
// done. dbg_state exposes the FSM state for observation.
module fa2_serial_ctrl
   import fa2_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             busy,
   output logic             done,
   output state_t           dbg_state
`ifdef FA2_SERIAL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / 2;
   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("fa2_serial_ctrl: WIDTH must be even and >= 2");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [1:0]       s_sum;
   logic             s_c0;
   logic             s_co;

   add2_slice u_slice (
      .a   (a_sh[1:0]),
      .b   (b_sh[1:0]),
      .ci  (carry),
      .sum (s_sum),
      .c0  (s_c0),
      .co  (s_co)
   );

   // New digit enters at the top of the accumulator; after N digits the
   // first digit has reached bits [1:0].
   generate
      if (WIDTH == 2) begin : g_acc_w2
         assign acc_nxt = s_sum;
      end else begin : g_acc_wide
         assign acc_nxt = {s_sum, acc[WIDTH-1:2]};
      end
   endgenerate

   assign dbg_state = state;

   // Sequencer: capture operands, step one digit per cycle, publish result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         co    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef FA2_SERIAL_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_FIN: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= ci;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_sh  <= a_sh >> 2;
               b_sh  <= b_sh >> 2;
               carry <= s_co;
               acc   <= acc_nxt;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum   <= acc_nxt;
                  co    <= s_co;
`ifdef FA2_SERIAL_OVF_EN
                  // Carry into the MSB is the slice's bit-0 carry on the last digit.
                  ovf   <= s_c0 ^ s_co;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_FIN;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef FA2_SERIAL_OVF_EN
   // The bit-0 carry only matters for overflow; keep it referenced otherwise.
   logic unused_c0;
   assign unused_c0 = s_c0;
`endif

endmodule

// File: tb/tb_fa2_serial_ctrl.sv
// Bench for fa2_serial_ctrl (WIDTH=8): directed scenarios with literal
// expectations plus randomized traffic against a job-level reference model.
module tb_fa2_serial_ctrl;
   import fa2_serial_pkg::*;

   localparam int W = 8;
   localparam int N = W / 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic [W-1:0] sum;
   logic         co;
   logic         busy;
   logic         done;
   state_t       dbg_state;
`ifdef FA2_SERIAL_OVF_EN
   logic         ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Clock and DUT
   always #5 clk = ~clk;

   fa2_serial_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sum       (sum),
      .co        (co),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
`ifdef FA2_SERIAL_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a job is a countdown of N edges, result is plain sum.
   int           m_left;
   logic         m_done;
   logic [W-1:0] m_a;
   logic [W-1:0] m_b;
   logic         m_ci;
   logic [W-1:0] m_sum;
   logic         m_co;
`ifdef FA2_SERIAL_OVF_EN
   logic         m_ovf;
`endif

   always @(posedge clk or posedge rst) begin
      logic [W:0] t;
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
         m_sum  = '0;
         m_co   = 1'b0;
`ifdef FA2_SERIAL_OVF_EN
         m_ovf  = 1'b0;
`endif
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            t = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_ci};
            m_sum = t[W-1:0];
            m_co  = t[W];
`ifdef FA2_SERIAL_OVF_EN
            m_ovf = (m_a[W-1] == m_b[W-1]) && (t[W-1] != m_a[W-1]);
`endif
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_left = N;
            m_a    = a;
            m_b    = b;
            m_ci   = ci;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      state_t es;
      if (rst !== 1'b1) begin
         es = (m_left > 0) ? ST_RUN : (m_done ? ST_FIN : ST_IDLE);
         check("cyc_busy", 64'(busy), 64'(m_left > 0));
         check("cyc_done", 64'(done), 64'(m_done));
         check("cyc_sum", 64'(sum), 64'(m_sum));
         check("cyc_co", 64'(co), 64'(m_co));
         check("cyc_state", 64'(dbg_state), 64'(es));
`ifdef FA2_SERIAL_OVF_EN
         check("cyc_ovf", 64'(ovf), 64'(m_ovf));
`endif
      end
   end

   // Driver: issue one job and wait for its done; lat counts edges after E0.
   task automatic job(input logic [W-1:0] ja, input logic [W-1:0] jb, input logic jci,
                      output int lat, output int bcnt);
      @(negedge clk);
      a = ja; b = jb; ci = jci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      bcnt = 0;
      for (int k = 0; k <= 20; k++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   // Watchdog
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt, dn, d1, d2;
      logic [W-1:0] s1, s2;
      logic c1, c2;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_sum", 64'(sum), 64'h0);
      check("rst_co", 64'(co), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      rst = 1'b0;

      // Wrap-around
      job(8'hFF, 8'h01, 1'b0, lat, bcnt);
      check("wrap_lat", 64'(lat), 64'd4);
      check("wrap_busy_cycles", 64'(bcnt), 64'd4);
      check("wrap_sum", 64'(sum), 64'h00);
      check("wrap_co", 64'(co), 64'h1);

      // Carry-in and overflow
      job(8'h5A, 8'h25, 1'b1, lat, bcnt);
      check("cin_sum", 64'(sum), 64'h80);
      check("cin_co", 64'(co), 64'h0);
`ifdef FA2_SERIAL_OVF_EN
      check("cin_ovf", 64'(ovf), 64'h1);
`endif
      job(8'h7F, 8'h01, 1'b0, lat, bcnt);
      check("ovf2_sum", 64'(sum), 64'h80);
`ifdef FA2_SERIAL_OVF_EN
      check("ovf2_ovf", 64'(ovf), 64'h1);
`endif

      // START while busy is ignored
      @(negedge clk);
      a = 8'h11; b = 8'h22; ci = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0; s1 = '0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (done) begin dn++; s1 = sum; end
         if (k == 2) begin a = 8'h77; b = 8'h99; ci = 1'b1; start = 1'b1; end
         if (k == 3) start = 1'b0;
      end
      check("busy_start_dones", 64'(dn), 64'd1);
      check("busy_start_sum", 64'(s1), 64'h33);

      // Back-to-back with START held
      @(negedge clk);
      a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      d1 = -1; d2 = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (done) begin
            if (d1 < 0) begin d1 = k; s1 = sum; c1 = co; end
            else begin d2 = k; s2 = sum; c2 = co; end
         end
         if (k == 1) begin a = 8'hF0; b = 8'h20; end
         if (k == 6) start = 1'b0;
      end
      check("b2b_done1", 64'(d1), 64'd4);
      check("b2b_done2", 64'(d2), 64'd9);
      check("b2b_sum1", 64'(s1), 64'h02);
      check("b2b_co1", 64'(c1), 64'h0);
      check("b2b_sum2", 64'(s2), 64'h10);
      check("b2b_co2", 64'(c2), 64'h1);

      // Reset mid-run
      @(negedge clk);
      a = 8'h3C; b = 8'h0F; ci = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_sum", 64'(sum), 64'h0);
      check("mid_rst_co", 64'(co), 64'h0);
      check("mid_rst_busy", 64'(busy), 64'h0);
      check("mid_rst_done", 64'(done), 64'h0);
      check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      check("mid_rst_no_done", 64'(dn), 64'd0);
      job(8'h3C, 8'h0F, 1'b0, lat, bcnt);
      check("post_rst_lat", 64'(lat), 64'd4);
      check("post_rst_sum", 64'(sum), 64'h4B);

      // Result hold while operands wiggle in IDLE
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      end
      @(posedge clk); #1;
      check("hold_sum", 64'(sum), 64'h4B);
      check("hold_co", 64'(co), 64'h0);

      // Randomized traffic: gaps, held starts, starts during run, rare resets
      for (int j = 0; j < 300; j++) begin
         int gap, hold;
         gap = $urandom_range(0, 3);
         hold = $urandom_range(1, 7);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start = 1'b0;
         end
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
         end
         @(negedge clk);
         start = 1'b0;
         if ($urandom_range(0, 39) == 0) begin
            #2;
            rst = 1'b1;
            @(negedge clk);
            #2;
            rst = 1'b0;
         end
      end
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fa2_serial_ctrl.md
# fa2_serial_ctrl

- Sequencing controller that performs a WIDTH-bit addition by reusing one 2-bit ripple-carry adder slice over WIDTH/2 clock cycles.
- It processes two bits per cycle, LSB pair first, and carries between digits in a register.
- It sits between a requester that issues START with operands and the shared 2-bit adder datapath.
- The result is reported with a single-cycle DONE pulse.

## Interface

Parameters:
- WIDTH, 8, operand width in bits. Must be even and ≥ 2; odd values are illegal and are rejected at elaboration.

Ports:
- CLK   input   1       rising-edge clock; the only clock.
- RST   input   1       asynchronous, active-high reset.
- START input   1       request; sampled on the CLK rising edge.
- A     input   WIDTH   operand A; sampled with an accepted START.
- B     input   WIDTH   operand B; sampled with an accepted START.
- CI    input   1       carry-in; sampled with an accepted START.
- SUM   output  WIDTH   registered result.
- CO    output  1       registered carry-out of the MSB.
- BUSY  output  1       high while a computation is in progress.
- DONE  output  1       one-cycle pulse; SUM/CO are valid for the new result.
- OVF   output  1       signed overflow; present only with FA2_SERIAL_OVF_EN.

## Operation

State machine with three states: IDLE, RUN, FIN.

- **IDLE:**
  - If START=1 at an edge: latch A, B and CI into internal shift registers, clear the digit counter, go to RUN.
- **RUN:**
  - Each edge feeds the low 2 bits of the A and B shift registers, plus the carry register, into the slice.
  - The 2-bit slice result is shifted into the top of the accumulator.
  - The carry register takes the slice carry-out.
  - The counter increments.
  - After digit N-1 (N = WIDTH/2), copy the accumulator into SUM and the final carry into CO, then go to FIN.
- **FIN:**
  - DONE=1 for exactly this cycle.
  - START=1 here is accepted exactly as in IDLE (back-to-back operation) and the next state is RUN.
  - Otherwise the next state is IDLE.
- **START in RUN:** ignored. It is not queued and does not disturb the operation in progress.
- **SUM/CO/OVF stability:** they change only on the transition into FIN and hold their value until the next result. Partial sums are never visible.
- **Outputs:**
  - BUSY = (state == RUN).
  - DONE = (state == FIN).
- **Arithmetic:**
  - Unsigned modulo 2^WIDTH.
  - CO = bit WIDTH of A+B+CI.
  - The counter is clog2(N) bits wide. The terminal count is N-1; N=1 (WIDTH=2) is legal.
- **Reset:**
  - Asserting RST at any time, including mid-RUN, immediately forces IDLE.
  - All outputs go to 0: SUM=0, CO=0, BUSY=0, DONE=0, OVF=0.
  - The internal registers are cleared.
  - An aborted operation produces no DONE.
  - After RST deasserts, the first START is accepted on the next edge.

## Timing

- Let edge E0 be the edge where START is accepted.
- Digits are computed on edges E1..EN.
- BUSY is high from after E0 to after EN: N cycles.
- DONE is high from after EN to after EN+1. Latency from START to DONE is N cycles (4 for WIDTH=8).
- Throughput with START held continuously: one result every N+1 cycles.
- A, B and CI are only needed at E0. Changes afterwards have no effect.

## Configuration

- **FA2_SERIAL_OVF_EN defined:**
  - The OVF port exists. OVF = carry into the MSB XOR CO.
  - It is computed in the last RUN cycle from the slice's internal bit-0 carry, and registered with SUM.
  - Reset value is 0.
- **Not defined:**
  - The OVF port and its logic are absent.
  - All other behaviour is identical.

## Structure

- **Package fa2_serial_pkg:**
  - State enum typedef (IDLE, RUN, FIN).
  - Encoding constants.
  - A function returning clog2(WIDTH/2) for counter sizing.
- **Sub-module add2_slice:** combinational 2-bit ripple adder.
  - Ports: A[1:0], B[1:0], CI, SUM[1:0], C0 (carry out of bit 0), CO.
  - Instantiated once. C0 feeds the OVF logic.

## Test plan

All scenarios use WIDTH=8.

1. **Wrap-around:** A=8'hFF, B=8'h01, CI=0 → SUM=8'h00, CO=1. BUSY high 4 cycles; DONE pulses exactly 4 cycles after the START edge.
2. **Carry-in:** A=8'h5A, B=8'h25, CI=1 → SUM=8'h80, CO=0; with OVF_EN, OVF=1. Then A=8'h7F, B=8'h01, CI=0 → SUM=8'h80, OVF=1.
3. **START while busy:** START asserted again 2 cycles into RUN with different operands → ignored. The first result (8'h11+8'h22 → 8'h33) is reported, and only one DONE pulse occurs.
4. **Back-to-back:** START held high for two jobs (8'h01+8'h01, then 8'hF0+8'h20) → DONE at cycles 4 and 9 after the first edge. Results are 8'h02/CO=0, then 8'h10/CO=1.
5. **Reset mid-run:** RST asserted at cycle 2 of RUN → outputs immediately 0, state IDLE, no DONE. A new START after release gives a correct result with 4-cycle latency.
6. **Result hold:** operands change while IDLE after DONE → SUM/CO unchanged until the next DONE.
